// File: rtl/pad_io_multi.sv
// MegaDrive/SMS controller-port emulator for NUM_PADS independent ports (3/6-button, SMS, TH float).
// Optional autofire timebase enabled by defining PAD_TURBO_EN.
module pad_io_multi #(
    parameter int unsigned NUM_PADS       = 2,
    parameter int unsigned TH_FLOAT_CYC   = 1470,
    parameter int unsigned JCNT_TMO_CYC   = 81200,
    parameter int unsigned TURBO_HALF_CYC = 1789772
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PADS-1:0]     mode6,
    input  logic [NUM_PADS-1:0]     sms,
    input  logic [12*NUM_PADS-1:0]  btn,
    input  logic [6*NUM_PADS-1:0]   turbo,
    input  logic [7*NUM_PADS-1:0]   port_in,
    input  logic [7*NUM_PADS-1:0]   port_dir,
    output logic [7*NUM_PADS-1:0]   port_out,
    output logic [2*NUM_PADS-1:0]   phase
);

    // Timer widths leave headroom so the all-ones value never matches a real threshold.
    localparam int unsigned FLT_W  = $clog2(TH_FLOAT_CYC + 2);
    localparam int unsigned JTMR_W = $clog2(JCNT_TMO_CYC + 2);

    logic tphase;

`ifdef PAD_TURBO_EN
    localparam int unsigned TURBO_W = (TURBO_HALF_CYC > 1) ? $clog2(TURBO_HALF_CYC) : 1;

    logic [TURBO_W-1:0] turbo_cnt;

    // Shared autofire timebase: tphase flips every TURBO_HALF_CYC clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            turbo_cnt <= '0;
            tphase    <= 1'b0;
        end else if (turbo_cnt == TURBO_W'(TURBO_HALF_CYC - 1)) begin
            turbo_cnt <= '0;
            tphase    <= ~tphase;
        end else begin
            turbo_cnt <= turbo_cnt + TURBO_W'(1);
        end
    end
`else
    assign tphase = 1'b1;
`endif

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [6:0]        in_p;
        logic [6:0]        dir_p;
        logic [11:0]       b;
        logic [5:0]        t;
        logic [11:0]       eb;
        logic              th;
        logic              thd;
        logic [1:0]        jcnt;
        logic [JTMR_W-1:0] jtmr;
        logic [FLT_W-1:0]  fltmr;
        logic [5:0]        pdata;
        logic [5:0]        pdata_nxt;

        assign in_p  = port_in[7*p +: 7];
        assign dir_p = port_dir[7*p +: 7];
        assign b     = btn[12*p +: 12];
        assign t     = turbo[6*p +: 6];

        // Autofire masks A,B,C,X,Y,Z while tphase is low.
        always_comb begin
            eb     = b;
            eb[4]  = b[4]  & ~(t[0] & ~tphase);
            eb[5]  = b[5]  & ~(t[1] & ~tphase);
            eb[6]  = b[6]  & ~(t[2] & ~tphase);
            eb[9]  = b[9]  & ~(t[3] & ~tphase);
            eb[10] = b[10] & ~(t[4] & ~tphase);
            eb[11] = b[11] & ~(t[5] & ~tphase);
        end

        // Internal TH follows the console, or floats high after a timeout when undriven.
        always_ff @(posedge clk) begin
            if (reset) begin
                th    <= 1'b1;
                fltmr <= '1;
            end else if (!dir_p[6]) begin
                th    <= in_p[6];
                fltmr <= '0;
            end else begin
                if (fltmr != '1)
                    fltmr <= fltmr + FLT_W'(1);
                if (fltmr == FLT_W'(TH_FLOAT_CYC))
                    th <= 1'b1;
            end
        end

        // 6-button phase counter; a rising edge beats the inactivity timeout.
        always_ff @(posedge clk) begin
            if (reset) begin
                thd  <= 1'b1;
                jtmr <= '0;
                jcnt <= '0;
            end else begin
                thd <= th;
                if (thd && !th)
                    jtmr <= '0;
                else if (jtmr != '1)
                    jtmr <= jtmr + JTMR_W'(1);

                if (!mode6[p] || sms[p])
                    jcnt <= '0;
                else if (!thd && th)
                    jcnt <= jcnt + 2'd1;
                else if (jtmr > JTMR_W'(JCNT_TMO_CYC))
                    jcnt <= '0;
            end
        end

        always_comb begin
            pdata_nxt = {~eb[6], ~eb[5], ~eb[3], ~eb[2], ~eb[1], ~eb[0]};
            if (sms[p]) begin
                pdata_nxt = {~eb[6], ~eb[5], ~eb[3], ~eb[2], ~eb[1], ~eb[0]};
            end else if (!th) begin
                case (jcnt)
                    2'd2:    pdata_nxt = {~eb[7], ~eb[4], 4'b0000};
                    2'd3:    pdata_nxt = {~eb[7], ~eb[4], 4'b1111};
                    default: pdata_nxt = {~eb[7], ~eb[4], 2'b00, ~eb[1], ~eb[0]};
                endcase
            end else if (jcnt == 2'd3) begin
                pdata_nxt = {~eb[6], ~eb[5], ~eb[8], ~eb[9], ~eb[10], ~eb[11]};
            end
        end

        always_ff @(posedge clk) begin
            if (reset)
                pdata <= 6'h3F;
            else
                pdata <= pdata_nxt;
        end

        assign port_out[7*p +: 7] = (~dir_p & in_p) | (dir_p & {1'b1, pdata});
        assign phase[2*p +: 2]    = jcnt;
    end

endmodule

// File: tb/tb_pad_io_multi.sv
// Directed bench for pad_io_multi: reset, 6-button sequence, timeout, TH float, mode6 drop, SMS, autofire.
module tb_pad_io_multi;

    localparam int unsigned NP  = 2;
    localparam int unsigned TFC = 30;
    localparam int unsigned TMO = 100;
    localparam int unsigned THC = 4;

    // pad0: UP,RIGHT,A,C,X held; pad1: DOWN,LEFT,B,Z held
    localparam logic [11:0] BTN0 = 12'h259;
    localparam logic [11:0] BTN1 = 12'h826;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     mode6;
    logic [NP-1:0]     sms;
    logic [12*NP-1:0]  btn;
    logic [6*NP-1:0]   turbo;
    logic [7*NP-1:0]   port_in;
    logic [7*NP-1:0]   port_dir;
    logic [7*NP-1:0]   port_out;
    logic [2*NP-1:0]   phase;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pad_io_multi #(
        .NUM_PADS      (NP),
        .TH_FLOAT_CYC  (TFC),
        .JCNT_TMO_CYC  (TMO),
        .TURBO_HALF_CYC(THC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .mode6   (mode6),
        .sms     (sms),
        .btn     (btn),
        .turbo   (turbo),
        .port_in (port_in),
        .port_dir(port_dir),
        .port_out(port_out),
        .phase   (phase)
    );

    task automatic test_reset();
        reset    = 1'b1;
        mode6    = 2'b01;
        sms      = 2'b00;
        btn      = {BTN1, BTN0};
        turbo    = '0;
        port_in  = '0;
        port_dir = {7'h3F, 7'h3F};
        repeat (3) @(negedge clk);
        n_cmp++;
        if (port_out !== {7'h3F, 7'h3F}) begin
            n_err++;
            $display("FAIL reset_out_dir3f: got %h want %h", port_out, {7'h3F, 7'h3F});
        end
        n_cmp++;
        if (phase !== 4'h0) begin
            n_err++;
            $display("FAIL reset_phase: got %h want 0", phase);
        end
        port_dir = {7'h40, 7'h40};
        #1;
        n_cmp++;
        if (port_out !== {7'h40, 7'h40}) begin
            n_err++;
            $display("FAIL reset_out_dir40: got %h want %h", port_out, {7'h40, 7'h40});
        end
        @(negedge clk);
        port_dir    = {7'h3F, 7'h3F};
        port_in[6]  = 1'b1;
        port_in[13] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (port_out !== {7'h69, 7'h56}) begin
            n_err++;
            $display("FAIL idle_th_high: got %h want %h", port_out, {7'h69, 7'h56});
        end
    endtask

    task automatic test_six_button();
        logic       th_v [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [6:0] eo   [8] = '{7'h22, 7'h56, 7'h22, 7'h56, 7'h20, 7'h5B, 7'h2F, 7'h56};
        logic [1:0] ep   [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        for (int i = 0; i < 8; i++) begin
            port_in[6] = th_v[i];
            repeat (20) @(negedge clk);
            n_cmp++;
            if (port_out[6:0] !== eo[i]) begin
                n_err++;
                $display("FAIL six_out step%0d: got %h want %h", i, port_out[6:0], eo[i]);
            end
            n_cmp++;
            if (phase[1:0] !== ep[i]) begin
                n_err++;
                $display("FAIL six_phase step%0d: got %0d want %0d", i, phase[1:0], ep[i]);
            end
        end
        n_cmp++;
        if (port_out[13:7] !== 7'h69 || phase[3:2] !== 2'd0) begin
            n_err++;
            $display("FAIL six_pad1_idle: got %h/%0d want 69/0", port_out[13:7], phase[3:2]);
        end
    endtask

    task automatic test_timeout();
        logic th_v [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            port_in[6] = th_v[i];
            repeat (20) @(negedge clk);
        end
        n_cmp++;
        if (port_out[6:0] !== 7'h20 || phase[1:0] !== 2'd2) begin
            n_err++;
            $display("FAIL tmo_pre: got %h/%0d want 20/2", port_out[6:0], phase[1:0]);
        end
        repeat (150) @(negedge clk);
        n_cmp++;
        if (phase[1:0] !== 2'd0) begin
            n_err++;
            $display("FAIL tmo_phase: got %0d want 0", phase[1:0]);
        end
        n_cmp++;
        if (port_out[6:0] !== 7'h22) begin
            n_err++;
            $display("FAIL tmo_low_out: got %h want 22", port_out[6:0]);
        end
        port_in[6] = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (port_out[6:0] !== 7'h56 || phase[1:0] !== 2'd0) begin
            n_err++;
            $display("FAIL tmo_high: got %h/%0d want 56/0", port_out[6:0], phase[1:0]);
        end
    endtask

    task automatic test_float();
        port_in[13] = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (port_out[13:7] !== 7'h31) begin
            n_err++;
            $display("FAIL float_driven_low: got %h want 31", port_out[13:7]);
        end
        port_dir[13] = 1'b1;
        repeat (TFC - 3) @(negedge clk);
        n_cmp++;
        if (port_out[13:7] !== 7'h71) begin
            n_err++;
            $display("FAIL float_early: got %h want 71", port_out[13:7]);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (port_out[13:7] !== 7'h69) begin
            n_err++;
            $display("FAIL float_late: got %h want 69", port_out[13:7]);
        end
        n_cmp++;
        if (port_out[6:0] !== 7'h56 || phase[1:0] !== 2'd0) begin
            n_err++;
            $display("FAIL float_pad0: got %h/%0d want 56/0", port_out[6:0], phase[1:0]);
        end
        port_dir[13] = 1'b0;
        port_in[13]  = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_mode6_drop();
        port_in[6] = 1'b0;
        repeat (20) @(negedge clk);
        port_in[6] = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (phase[1:0] !== 2'd1) begin
            n_err++;
            $display("FAIL m6_before: got %0d want 1", phase[1:0]);
        end
        mode6[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (phase[1:0] !== 2'd0) begin
            n_err++;
            $display("FAIL m6_drop: got %0d want 0", phase[1:0]);
        end
    endtask

    task automatic test_sms();
        mode6[1] = 1'b1;
        sms[1]   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            port_in[13] = (i % 2 == 1);
            repeat (20) @(negedge clk);
            n_cmp++;
            if (port_out[13:7] !== {port_in[13], 6'h29} || phase[3:2] !== 2'd0) begin
                n_err++;
                $display("FAIL sms step%0d: got %h/%0d want %h/0", i, port_out[13:7], phase[3:2],
                         {port_in[13], 6'h29});
            end
        end
        sms[1]   = 1'b0;
        mode6[1] = 1'b0;
    endtask

    task automatic test_turbo();
        port_in[6] = 1'b0;
        turbo[0]   = 1'b1;
        repeat (10) @(negedge clk);
`ifdef PAD_TURBO_EN
        begin
            int  w;
            logic exp_v;
            w = 0;
            while (port_out[4] !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            while (port_out[4] !== 1'b0 && w < 20) begin
                @(negedge clk);
                w++;
            end
            n_cmp++;
            if (w >= 20) begin
                n_err++;
                $display("FAIL turbo_sync: got no 1->0 edge on D4 want edge within 20 cycles");
            end else begin
                for (int k = 1; k < 16; k++) begin
                    @(negedge clk);
                    exp_v = ((k / 4) % 2 == 1);
                    n_cmp++;
                    if (port_out[4] !== exp_v) begin
                        n_err++;
                        $display("FAIL turbo_d4 k%0d: got %b want %b", k, port_out[4], exp_v);
                    end
                end
            end
        end
`else
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_cmp++;
            if (port_out[6:0] !== 7'h22) begin
                n_err++;
                $display("FAIL turbo_off k%0d: got %h want 22", k, port_out[6:0]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_six_button();
        test_timeout();
        test_float();
        test_mode6_drop();
        test_sms();
        test_turbo();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
